// File: rtl/uop_queue_mp.sv
// uop_queue_mp: multi-port circular uop queue.
// Up to IN_W uops are enqueued per cycle, all-or-nothing. Up to OUT_W head
// entries are presented show-ahead, and the consumer dequeues 0..OUT_W of them.
// Space, availability and acceptance all come from start-of-cycle state, so a
// same-cycle dequeue never frees room for a same-cycle enqueue, and there is no
// bypass path from the enqueue lanes to the output lanes.
// Pointers are one bit wider than the index, so full and empty can be told
// apart without a separate count register.
module uop_queue_mp #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2,
   parameter int DEPTH = 16,
   parameter int UW    = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [$clog2(IN_W+1)-1:0]    in_count,
   input  logic [IN_W*UW-1:0]           in_uop,
   output logic [$clog2(DEPTH+1)-1:0]   in_space,
   output logic [OUT_W*UW-1:0]          out_uop,
   output logic [$clog2(OUT_W+1)-1:0]   out_avail,
   input  logic [$clog2(OUT_W+1)-1:0]   out_take,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   peak_occ,
   output logic                         err_ovf,
   output logic                         err_udf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(IN_W + 1);
   localparam int TW = $clog2(OUT_W + 1);

   // Storage is deliberately left out of reset; only pointers and flags are cleared.
   logic [UW-1:0] mem_r [DEPTH];

   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [PW-1:0] peak_r;
   logic          err_ovf_r;
   logic          err_udf_r;

   logic [PW-1:0] occ_s;
   logic [PW-1:0] space_s;
   logic [TW-1:0] avail_s;
   logic          enq_req_s;
   logic          enq_ok_s;
   logic          ovf_s;
   logic          udf_s;
   logic [TW-1:0] taken_s;
   logic [PW-1:0] head_n_s;
   logic [PW-1:0] tail_n_s;
   logic [PW-1:0] occ_n_s;
   logic [PW-1:0] peak_n_s;
   logic          err_ovf_n_s;
   logic          err_udf_n_s;
   logic [OUT_W*UW-1:0] out_uop_s;

   // Entry index of (pointer + offset), wrapping modulo DEPTH.
   function automatic logic [AW-1:0] ent_idx(input logic [PW-1:0] ptr, input int off);
      logic [PW-1:0] sum;
      sum = ptr + PW'(off);
      return sum[AW-1:0];
   endfunction

   assign occ_s   = tail_r - head_r;
   assign space_s = PW'(DEPTH) - occ_s;
   assign avail_s = (occ_s >= PW'(OUT_W)) ? TW'(OUT_W) : TW'(occ_s);

   // Enqueue acceptance, dequeue clamp and next-state pointers, peak and flags.
   always_comb begin
      enq_req_s   = in_valid && (in_count != {CW{1'b0}});
      enq_ok_s    = 1'b0;
      ovf_s       = 1'b0;
      udf_s       = 1'b0;
      taken_s     = out_take;
      head_n_s    = head_r;
      tail_n_s    = tail_r;
      occ_n_s     = occ_s;
      peak_n_s    = peak_r;
      err_ovf_n_s = err_ovf_r;
      err_udf_n_s = err_udf_r;

      // A count wider than the lane array is rejected like any other overflow.
      if (enq_req_s && (in_count <= CW'(IN_W)) && (PW'(in_count) <= space_s)) begin
         enq_ok_s = 1'b1;
      end else begin
         enq_ok_s = 1'b0;
      end
      ovf_s = enq_req_s && !enq_ok_s;

      if (out_take > avail_s) begin
         udf_s   = 1'b1;
         taken_s = avail_s;
      end else begin
         udf_s   = 1'b0;
         taken_s = out_take;
      end

      // Flush wins over any same-cycle traffic and leaves the sticky flags alone.
      if (flush) begin
         head_n_s = {PW{1'b0}};
         tail_n_s = {PW{1'b0}};
         occ_n_s  = {PW{1'b0}};
         peak_n_s = {PW{1'b0}};
      end else begin
         head_n_s = head_r + PW'(taken_s);
         if (enq_ok_s) begin
            tail_n_s = tail_r + PW'(in_count);
         end else begin
            tail_n_s = tail_r;
         end
         occ_n_s = tail_n_s - head_n_s;
         if (occ_n_s > peak_r) begin
            peak_n_s = occ_n_s;
         end else begin
            peak_n_s = peak_r;
         end
         err_ovf_n_s = err_ovf_r | ovf_s;
         err_udf_n_s = err_udf_r | udf_s;
      end
   end

   // Pointer, high-water mark and sticky flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r    <= {PW{1'b0}};
         tail_r    <= {PW{1'b0}};
         peak_r    <= {PW{1'b0}};
         err_ovf_r <= 1'b0;
         err_udf_r <= 1'b0;
      end else begin
         head_r    <= head_n_s;
         tail_r    <= tail_n_s;
         peak_r    <= peak_n_s;
         err_ovf_r <= err_ovf_n_s;
         err_udf_r <= err_udf_n_s;
      end
   end

   // Write accepted lanes into consecutive entries starting at the tail.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_W; i++) begin
         if (reset && !flush && enq_ok_s && (CW'(i) < in_count)) begin
            mem_r[ent_idx(tail_r, i)] <= in_uop[i*UW +: UW];
         end
      end
   end

   // Show-ahead head lanes; lanes beyond the available count read as zero.
   always_comb begin
      out_uop_s = {(OUT_W*UW){1'b0}};
      for (int i = 0; i < OUT_W; i++) begin
         if (TW'(i) < avail_s) begin
            out_uop_s[i*UW +: UW] = mem_r[ent_idx(head_r, i)];
         end else begin
            out_uop_s[i*UW +: UW] = {UW{1'b0}};
         end
      end
   end

   assign out_uop   = out_uop_s;
   assign out_avail = avail_s;
   assign in_space  = space_s;
   assign occupancy = occ_s;
   assign empty     = (occ_s == {PW{1'b0}});
   assign full      = (occ_s == PW'(DEPTH));
   assign peak_occ  = peak_r;
   assign err_ovf   = err_ovf_r;
   assign err_udf   = err_udf_r;

endmodule

// File: tb/tb_uop_queue_mp.sv
// tb_uop_queue_mp: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the uop queue.
module tb_uop_queue_mp;

   localparam int IN_W  = 4;
   localparam int OUT_W = 2;
   localparam int DEPTH = 16;
   localparam int UW    = 64;

   logic                clk;
   logic                reset;
   logic                flush;
   logic                in_valid;
   logic [2:0]          in_count;
   logic [IN_W*UW-1:0]  in_uop;
   logic [4:0]          in_space;
   logic [OUT_W*UW-1:0] out_uop;
   logic [1:0]          out_avail;
   logic [1:0]          out_take;
   logic [4:0]          occupancy;
   logic                empty;
   logic                full;
   logic [4:0]          peak_occ;
   logic                err_ovf;
   logic                err_udf;

   uop_queue_mp #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .UW(UW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_count(in_count), .in_uop(in_uop), .in_space(in_space),
      .out_uop(out_uop), .out_avail(out_avail), .out_take(out_take),
      .occupancy(occupancy), .empty(empty), .full(full), .peak_occ(peak_occ),
      .err_ovf(err_ovf), .err_udf(err_udf)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [UW-1:0] mq[$];
   int  m_peak = 0;
   bit  m_ovf  = 1'b0;
   bit  m_udf  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [255:0] pack4(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d);
      return {d, c, b, a};
   endfunction

   // Apply one clock edge of the queue rules to the model.
   task automatic model_edge(input bit v, input int cnt, input logic [255:0] lanes,
                             input int take, input bit fl);
      int s;
      int avail;
      int taken;
      bit acc;
      s     = mq.size();
      avail = (s < OUT_W) ? s : OUT_W;
      if (fl) begin
         mq.delete();
         m_peak = 0;
      end else begin
         acc = 1'b0;
         if (v && cnt > 0) begin
            if (cnt <= DEPTH - s) acc = 1'b1;
            else m_ovf = 1'b1;
         end
         if (take > avail) m_udf = 1'b1;
         taken = (take > avail) ? avail : take;
         for (int i = 0; i < taken; i++) void'(mq.pop_front());
         if (acc) for (int i = 0; i < cnt; i++) mq.push_back(lanes[i*UW +: UW]);
         if (mq.size() > m_peak) m_peak = mq.size();
      end
   endtask

   // Compare every DUT output against the model.
   task automatic check_model();
      int s;
      int avail;
      logic [UW-1:0] exp_lane;
      s     = mq.size();
      avail = (s < OUT_W) ? s : OUT_W;
      chk("occupancy", occupancy, s);
      chk("in_space", in_space, DEPTH - s);
      chk("out_avail", out_avail, avail);
      chk("empty", empty, s == 0);
      chk("full", full, s == DEPTH);
      chk("peak_occ", peak_occ, m_peak);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_udf", err_udf, m_udf);
      for (int i = 0; i < OUT_W; i++) begin
         exp_lane = (i < avail) ? mq[i] : '0;
         chk($sformatf("out_uop[%0d]", i), out_uop[i*UW +: UW], exp_lane);
      end
   endtask

   // Drive one cycle of stimulus (from just after a falling edge), clock it, then check.
   task automatic step(input bit v, input int cnt, input logic [255:0] lanes,
                       input int take, input bit fl);
      in_valid = v;
      in_count = 3'(cnt);
      in_uop   = lanes;
      out_take = 2'(take);
      flush    = fl;
      @(posedge clk);
      model_edge(v, cnt, lanes, take, fl);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_count = 3'd0;
      out_take = 2'd0;
      flush    = 1'b0;
   endtask

   logic [255:0] rl;
   int r_take;

   // Main sequence: directed cases, random traffic, asynchronous reset.
   initial begin
      reset  = 1'b0;
      in_uop = '0;
      idle();
      #1;
      chk("rst occupancy", occupancy, 5'd0);
      chk("rst in_space", in_space, 5'd16);
      chk("rst empty", empty, 1'b1);
      chk("rst full", full, 1'b0);
      chk("rst out_avail", out_avail, 2'd0);
      chk("rst out_uop", out_uop[63:0] | out_uop[127:64], 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Three-lane enqueue then a two-uop take.
      step(1'b1, 3, pack4(64'hA, 64'hB, 64'hC, 64'hDEAD), 0, 1'b0);
      chk("basic occ", occupancy, 5'd3);
      chk("basic avail", out_avail, 2'd2);
      chk("basic lane0", out_uop[63:0], 64'hA);
      chk("basic lane1", out_uop[127:64], 64'hB);
      step(1'b0, 0, '0, 2, 1'b0);
      chk("take avail", out_avail, 2'd1);
      chk("take lane0", out_uop[63:0], 64'hC);
      chk("take lane1", out_uop[127:64], 64'h0);

      // Fill to 14, overflow rejected, then exactly fill.
      for (int k = 0; k < 3; k++) step(1'b1, 4, pack4(64'h10+k, 64'h20+k, 64'h30+k, 64'h40+k), 0, 1'b0);
      step(1'b1, 1, pack4(64'h50, 64'h0, 64'h0, 64'h0), 0, 1'b0);
      chk("fill occ", occupancy, 5'd14);
      step(1'b1, 3, pack4(64'h61, 64'h62, 64'h63, 64'h0), 0, 1'b0);
      chk("ovf occ", occupancy, 5'd14);
      chk("ovf flag", err_ovf, 1'b1);
      step(1'b1, 2, pack4(64'h71, 64'h72, 64'h0, 64'h0), 0, 1'b0);
      chk("full flag", full, 1'b1);
      chk("full space", in_space, 5'd0);

      // Full queue: enqueue rejected while the dequeue still happens.
      step(1'b1, 2, pack4(64'h81, 64'h82, 64'h0, 64'h0), 2, 1'b0);
      chk("full sim occ", occupancy, 5'd14);

      // Move head to entry 14 and enqueue across the wrap.
      step(1'b0, 0, '0, 0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 4, pack4(64'h1, 64'h2, 64'h3, 64'h4), 0, 1'b0);
      step(1'b1, 2, pack4(64'h5, 64'h6, 64'h0, 64'h0), 0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 0, '0, 2, 1'b0);
      chk("wrap pre empty", empty, 1'b1);
      step(1'b1, 4, pack4(64'hE0, 64'hE1, 64'hE2, 64'hE3), 0, 1'b0);
      chk("wrap occ", occupancy, 5'd4);
      chk("wrap lane0a", out_uop[63:0], 64'hE0);
      chk("wrap lane1a", out_uop[127:64], 64'hE1);
      step(1'b0, 0, '0, 2, 1'b0);
      chk("wrap lane0b", out_uop[63:0], 64'hE2);
      chk("wrap lane1b", out_uop[127:64], 64'hE3);
      step(1'b0, 0, '0, 2, 1'b0);

      // Over-take with one entry, then flush with a same-cycle enqueue.
      step(1'b1, 1, pack4(64'hF0, 64'h0, 64'h0, 64'h0), 0, 1'b0);
      step(1'b0, 0, '0, 2, 1'b0);
      chk("udf empty", empty, 1'b1);
      chk("udf flag", err_udf, 1'b1);
      step(1'b1, 2, pack4(64'hF1, 64'hF2, 64'h0, 64'h0), 0, 1'b1);
      chk("flush occ", occupancy, 5'd0);
      chk("flush peak", peak_occ, 5'd0);
      chk("flush udf", err_udf, 1'b1);

      // Randomized traffic with occasional flushes.
      for (int c = 0; c < 3000; c++) begin
         for (int w = 0; w < 8; w++) rl[w*32 +: 32] = $urandom;
         r_take = (c % 1000 < 500) ? $urandom_range(0, 1) : $urandom_range(0, 3);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4), rl, r_take,
              $urandom_range(0, 99) == 0);
      end

      // Build occupancy 5 and assert reset between edges.
      step(1'b0, 0, '0, 0, 1'b1);
      step(1'b1, 4, pack4(64'h91, 64'h92, 64'h93, 64'h94), 0, 1'b0);
      step(1'b1, 1, pack4(64'h95, 64'h0, 64'h0, 64'h0), 3, 1'b0);
      idle();
      chk("pre-rst occ", occupancy, 5'd3);
      step(1'b1, 2, pack4(64'h96, 64'h97, 64'h0, 64'h0), 0, 1'b0);
      chk("pre-rst occ5", occupancy, 5'd5);
      idle();
      #2 reset = 1'b0;
      #1;
      mq.delete();
      m_peak = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      chk("async occ", occupancy, 5'd0);
      chk("async empty", empty, 1'b1);
      chk("async avail", out_avail, 2'd0);
      chk("async lanes", out_uop[63:0] | out_uop[127:64], 64'd0);
      chk("async ovf", err_ovf, 1'b0);
      chk("async udf", err_udf, 1'b0);
      chk("async peak", peak_occ, 5'd0);
      chk("async space", in_space, 5'd16);
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, 2, pack4(64'hA1, 64'hA2, 64'h0, 64'h0), 0, 1'b0);
      chk("post-rst occ", occupancy, 5'd2);
      chk("post-rst lane0", out_uop[63:0], 64'hA1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uop_queue_mp.md
UOP_QUEUE_MP -- requirements
Module: uop_queue_mp

Interface
REQ-001 SHALL have parameter IN_W, default 4, meaning the maximum number of uops enqueued per cycle.
REQ-002 SHALL have parameter OUT_W, default 2, meaning the maximum number of uops presented and dequeued per cycle.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of queue entries; it must be a power of 2 and at least max(IN_W, OUT_W).
REQ-004 SHALL have parameter UW, default 64, meaning the width of one uop in bits.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-low: asserted when 0.
REQ-007 SHALL have port flush  in  1  synchronous clear of queue contents.
REQ-008 SHALL have port in_valid  in  1  enqueue request.
REQ-009 SHALL have port in_count  in  $clog2(IN_W+1)  number of valid lanes in in_uop, filled from lane 0.
REQ-010 SHALL have port in_uop  in  IN_W*UW  enqueue lanes; lane 0 is the oldest.
REQ-011 SHALL have port in_space  out  $clog2(DEPTH+1)  free entries, DEPTH minus occupancy.
REQ-012 SHALL have port out_uop  out  OUT_W*UW  show-ahead head entries; lane 0 is the oldest.
REQ-013 SHALL have port out_avail  out  $clog2(OUT_W+1)  min(occupancy, OUT_W).
REQ-014 SHALL have port out_take  in  $clog2(OUT_W+1)  number of uops the consumer dequeues this cycle.
REQ-015 SHALL have port occupancy  out  $clog2(DEPTH+1)  entries held.
REQ-016 SHALL have port empty  out  1  occupancy == 0.
REQ-017 SHALL have port full  out  1  occupancy == DEPTH.
REQ-018 SHALL have port peak_occ  out  $clog2(DEPTH+1)  high-water mark of occupancy.
REQ-019 SHALL have port err_ovf  out  1  sticky enqueue-overflow flag.
REQ-020 SHALL have port err_udf  out  1  sticky over-take flag.

Function
REQ-021 SHALL keep head and tail pointers of log2(DEPTH)+1 bits; occupancy = tail - head modulo 2^(log2(DEPTH)+1), and entry index = pointer[log2(DEPTH)-1:0], wrapping modulo DEPTH.
REQ-022 SHALL accept an enqueue when in_valid=1, in_count>0 and in_count<=in_space, writing lane i to entry tail+i and advancing tail by in_count.
REQ-023 SHALL treat enqueue as all-or-nothing: if in_valid=1 and in_count>in_space, write no entries, leave tail unchanged, and set err_ovf.
REQ-024 SHALL ignore in_valid=1 with in_count=0 and SHALL not set an error for it.
REQ-025 SHALL drive out_uop lane i from entry head+i combinationally for i<out_avail, and SHALL drive lanes i>=out_avail to 0.
REQ-026 SHALL advance head by min(out_take, out_avail) on the clock edge.
REQ-027 SHALL set err_udf when out_take>out_avail; the dequeue is clamped to out_avail in that case.
REQ-028 SHALL compute in_space, out_avail and enqueue acceptance from start-of-cycle state only: a same-cycle dequeue does not free space for a same-cycle enqueue.
REQ-029 SHALL make enqueued uops visible on out_uop/out_avail the cycle after acceptance, with no same-cycle bypass.
REQ-030 SHALL support simultaneous enqueue and dequeue, updating occupancy by +in_count-taken in one cycle.
REQ-031 SHALL have flush=1 set head=tail=0 on the next edge and override any same-cycle enqueue or dequeue.
REQ-032 SHALL have flush leave err_ovf and err_udf unchanged.
REQ-033 SHALL have flush reset peak_occ to 0.
REQ-034 SHALL update peak_occ to max(peak_occ, next occupancy) each cycle, where next occupancy is the post-edge value.
REQ-035 SHALL keep err_ovf and err_udf set until reset; flush does not clear them.
REQ-036 SHALL not reset storage contents; only pointers, flags and peak_occ are reset.

Reset
REQ-037 SHALL, while reset=0 and independent of clk, force head=0, tail=0, peak_occ=0, err_ovf=0 and err_udf=0.
REQ-038 SHALL, while reset=0, produce outputs occupancy=0, in_space=DEPTH, empty=1, full=0, out_avail=0 and out_uop all-zero.
REQ-039 SHALL discard any in-flight enqueue or dequeue when reset is asserted mid-operation, with no partial pointer update.
REQ-040 SHALL have the first enqueue accepted on the first rising clk edge after reset returns to 1.

Verification
REQ-041 Reset, then enqueue in_count=3 of A,B,C -> next cycle occupancy=3, out_avail=2, out_uop={A,B}; take 2 -> out_avail=1, lane0=C, lane1=0.
REQ-042 With default parameters, fill to 14, then enqueue in_count=3 -> rejected, occupancy stays 14 and err_ovf=1; then enqueue in_count=2 -> full=1, in_space=0.
REQ-043 With head at 14, enqueue 4 -> entries 14,15,0,1 are written, and dequeuing returns them in order across the wrap.
REQ-044 With occupancy=16, in_count=2 and out_take=2 in the same cycle -> enqueue rejected (err_ovf=1) and dequeue done, giving occupancy=14.
REQ-045 With occupancy=1, out_take=2 -> one uop removed, err_udf=1, empty=1 the next cycle; then flush with in_valid=1 -> occupancy=0, peak_occ=0 and err_udf still 1.
REQ-046 Assert reset=0 mid-cycle between edges with occupancy=5 -> outputs immediately show occupancy=0, empty=1, out_avail=0 and cleared flags.
